// File: rtl/mips_pkg.sv
// Shared widths, default encodings and helpers for the MIPS pipeline.
package mips_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // sll $0,$0,0 -- the canonical bubble
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0]    DEF_RESET_PC  = 32'h0000_0000;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter flip-flop: async active-low reset, load when enabled,
// otherwise holds its value.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] pc_next_i,
  output logic [PC_W-1:0] pc_o
);

  // PC state: reset to the aligned boot address, load on enable, else hold
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o <= word_align(RESET_PC);
    end else if (load_i) begin
      pc_o <= pc_next_i;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register. Selects the next PC
// (redirect > stall > sequential), drives the instruction-memory address
// and registers each fetched word with its PC+4 for decode.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = DEF_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_plus4_o,
  output logic               valid_o
);

  // ---- stage p0: fetch (PC register, next-PC select) ----
  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_plus4_p0;
  logic [PC_W-1:0] pc_next_p0;
  logic            pc_load_p0;

  // Sequential successor; the adder wraps naturally at 2^32.
  assign pc_plus4_p0 = pc_p0 + PC_W'(4);

  // A redirect overrides a stall: a stall on a wrong-path fetch is moot.
  assign pc_load_p0 = redirect_i | ~stall_i;

  // Next-PC mux: redirect target (word aligned) or sequential PC+4
  always_comb begin
    pc_next_p0 = pc_plus4_p0;
    if (redirect_i) begin
      pc_next_p0 = word_align(redirect_pc_i);
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (pc_load_p0),
    .pc_next_i (pc_next_p0),
    .pc_o      (pc_p0)
  );

  assign imem_addr_o = pc_p0;

  // ---- stage p1: IF/ID register ----
  logic [INSTR_W-1:0] instr_p1;
  logic [PC_W-1:0]    pc_plus4_p1;
  logic               vld_p1;

  // IF/ID capture: redirect inserts a bubble, stall freezes, else capture fetch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_p1    <= NOP_INSTR;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (redirect_i) begin
      instr_p1    <= NOP_INSTR;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (!stall_i) begin
      instr_p1    <= imem_data_i;
      pc_plus4_p1 <= pc_plus4_p0;
      vld_p1      <= 1'b1;
    end
  end

  assign instr_o    = instr_p1;
  assign pc_plus4_o = pc_plus4_p1;
  assign valid_o    = vld_p1;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, sequential fetch, stall,
// redirect under stall, PC wrap-around and asynchronous reset.
module tb_if_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  int n_checks = 0;
  int n_errors = 0;

  if_id_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory: addi $t0,$0,5 at 0, elsewhere 0xC000_0000 ^ addr.
  assign imem_data_i = (imem_addr_o == 32'h0) ? 32'h2008_0005
                                              : (32'hC000_0000 ^ imem_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                         input logic [31:0] p4, input logic vld);
    chk({tag, ".addr"},  imem_addr_o, addr);
    chk({tag, ".instr"}, instr_o, instr);
    chk({tag, ".pc4"},   pc_plus4_o, p4);
    chk({tag, ".vld"},   {31'd0, valid_o}, {31'd0, vld});
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

    // Reset held for 3 cycles
    repeat (3) begin
      step();
      chk_all("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    end
    rst_i = 1'b1;

    // First capture after release, then sequential fetch
    step(); chk_all("first", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    step(); chk_all("seq8",  32'h8, 32'hC000_0004, 32'h8, 1'b1);

    // Stall for 2 cycles at PC = 8
    stall_i = 1'b1;
    step(); chk_all("stall1", 32'h8, 32'hC000_0004, 32'h8, 1'b1);
    step(); chk_all("stall2", 32'h8, 32'hC000_0004, 32'h8, 1'b1);
    stall_i = 1'b0;
    step(); chk_all("resume", 32'hC, 32'hC000_0008, 32'hC, 1'b1);
    step(); chk_all("seq16", 32'h10, 32'hC000_000C, 32'h10, 1'b1);

    // Redirect to 0x43 (aligned to 0x40) while stalled: redirect wins
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0043;
    step(); chk_all("redir", 32'h40, 32'h0, 32'h0, 1'b0);
    stall_i = 1'b0; redirect_i = 1'b0;
    step(); chk_all("target", 32'h44, 32'hC000_0040, 32'h44, 1'b1);

    // Wrap-around: redirect to 0xFFFF_FFFF lands on 0xFFFF_FFFC
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    step(); chk_all("wrapredir", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    redirect_i = 1'b0;
    step(); chk_all("wrap", 32'h0, 32'h3FFF_FFFC, 32'h0, 1'b1);
    step(); chk_all("wrapnext", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

    // Async reset between edges during a stall
    stall_i = 1'b1;
    step(); chk_all("prerst", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    #2 rst_i = 1'b0;
    #1 chk_all("asyncrst", 32'h0, 32'h0, 32'h0, 1'b0);

    // A redirect pending during reset must not survive it
    stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    step(); chk_all("rstredir", 32'h0, 32'h0, 32'h0, 1'b0);
    redirect_i = 1'b0; rst_i = 1'b1;
    step(); chk_all("postrst", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS datapath. Holds the program counter, drives the instruction-memory address, and registers each fetched instruction with its PC+4 for the decode stage. Decode takes `instr_o[15:0]` directly into the 16-to-32 sign-extend unit and `instr_o[31:16]` into the register file and control. Supports load-use stalls and branch/jump redirects with a one-bubble flush.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value while reset is asserted; must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0000: encoding loaded into the IF/ID register on reset and on flush (`sll $0,$0,0`).

Ports:
- `clk_i`  in  1: single clock, all state updates on the rising edge.
- `rst_i`  in  1: asynchronous, active-low reset.
- `stall_i`  in  1: hazard unit freezes the PC and the IF/ID register.
- `redirect_i`  in  1: a taken branch or jump resolved in a later stage.
- `redirect_pc_i`  in  32: target for `redirect_i`; bits [1:0] ignored.
- `imem_addr_o`  out  32: instruction-memory address, equal to the current PC. Combinational from the PC register.
- `imem_data_i`  in  32: instruction word at `imem_addr_o`; combinational read, valid in the same cycle.
- `instr_o`  out  32: registered instruction for decode.
- `pc_plus4_o`  out  32: registered PC+4 of `instr_o`, used by the branch-target adder.
- `valid_o`  out  1: `instr_o` is a real fetched instruction, not a bubble.

## Operation

State:
- PC register (32 bits).
- IF/ID register: `instr_o`, `pc_plus4_o`, `valid_o`.

Next-PC selection, highest priority first:
1. `redirect_i`: next PC = `{redirect_pc_i[31:2], 2'b00}`.
2. `stall_i`: PC holds.
3. Otherwise: next PC = PC + 4, modulo 2^32.

IF/ID update:
- **Redirect** (regardless of `stall_i`): load `instr_o = NOP_INSTR`, `pc_plus4_o = 0`, `valid_o = 0`. This discards the wrong-path fetch.
- **Stall without redirect:** all IF/ID fields hold their values.
- **Normal:** load `instr_o = imem_data_i`, `pc_plus4_o = PC + 4`, `valid_o = 1`.

Other rules:
- Redirect and stall in the same cycle: redirect wins. A stall on a wrong-path instruction is meaningless.
- `imem_addr_o[1:0]` is always 2'b00.
- No internal stall or redirect counters. Stall duration is owned entirely by the hazard unit.

## Timing

- Reset, asserted asynchronously while `rst_i` = 0: PC = `RESET_PC`, `imem_addr_o = RESET_PC`, `instr_o = NOP_INSTR`, `pc_plus4_o = 0`, `valid_o = 0`.
- Reset released: the first rising edge captures the instruction at `RESET_PC` and sets `valid_o = 1`. The PC becomes `RESET_PC + 4`.
- Fetch-to-decode latency: 1 cycle. In steady state, throughput is one instruction per cycle.
- Redirect asserted in cycle N:
  - `imem_addr_o` equals the target in cycle N+1.
  - A bubble is visible on the outputs in cycle N+1.
  - The target instruction appears on `instr_o` in cycle N+2.
- Stall held for k cycles: outputs and `imem_addr_o` are frozen for exactly k cycles. The fetch resumes in the cycle after `stall_i` drops.
- Wrap-around: PC 32'hFFFF_FFFC advances to 32'h0000_0000, and `pc_plus4_o` = 0 for that instruction.
- Reset asserted mid-stall or mid-redirect: reset overrides everything immediately (asynchronous). No pending redirect survives reset.

## Structure

Shared package (`mips_pkg`):
- `PC_W` = 32, `INSTR_W` = 32.
- `NOP_INSTR` default.
- `RESET_PC` default.

Sub-module:
- `pc_reg`: the PC flip-flop with async active-low reset, hold enable and load.
- Next-PC mux and IF/ID register stay in `if_id_stage`.

## Test plan

- **Reset:** hold `rst_i` = 0 for 3 cycles, imem returning 32'h2008_0005 at address 0 → `valid_o` = 0 and `instr_o` = 0 during reset. The first edge after release gives `instr_o` = 32'h2008_0005, `pc_plus4_o` = 4, `imem_addr_o` = 4.
- **Sequential fetch:** 4 cycles with no stall or redirect → `pc_plus4_o` steps 4, 8, 12, 16, one per cycle, and `valid_o` stays 1.
- **Stall:** hold `stall_i` for 2 cycles at PC = 8 → `imem_addr_o` stays 8 and `instr_o` is unchanged for 2 cycles. Cycle 3 captures the word at address 8.
- **Redirect:** pulse `redirect_i` with `redirect_pc_i` = 32'h0000_0043 while `stall_i` = 1 → next cycle `imem_addr_o` = 32'h40, `valid_o` = 0, `instr_o` = NOP. The cycle after that, `instr_o` = word at 32'h40 and `pc_plus4_o` = 32'h44.
- **Wrap-around:** force the PC to 32'hFFFF_FFFC via redirect → the next capture gives `pc_plus4_o` = 0 and `imem_addr_o` = 0.
- **Async reset mid-operation:** drop `rst_i` between clock edges during a stall → outputs return to reset values immediately, without waiting for a clock edge.
